// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Purpose:
//   Bit-serial WIDTH-bit ALU controller built around a single one-bit ALU
//   slice (alu1bit, defined below in this file). It takes parallel operands
//   and an op code, then feeds the slice one bit per clock, LSB first. The
//   carry is chained through a flop, and the parallel result is assembled in
//   a right-shifting register. This costs WIDTH cycles of latency but needs
//   only one slice.
//
// Optional feature:
//   ALU_SERIAL_OVF_EN - when defined, this adds the ovf output. ovf is the
//   signed overflow for ADD/SUB and is held at 0 for NOR/XOR. When the macro
//   is undefined, neither the port nor its flop exists.
//
// Ports:
//   clk       in   1      clock, all state changes on the rising edge
//   rst       in   1      synchronous reset, active-high
//   in_valid  in   1      operand request valid
//   in_ready  out  1      controller is idle and can accept a request
//   a, b      in   WIDTH  operands
//   op        in   2      00 NOR, 01 XOR, 10 ADD (a+b), 11 SUB (a-b)
//   out_valid out  1      result valid (held until out_ready)
//   out_ready in   1      consumer accepts the result
//   s         out  WIDTH  result
//   cout      out  1      unsigned carry out for ADD/SUB; 0 for NOR/XOR
//   ovf       out  1      signed overflow (only with ALU_SERIAL_OVF_EN)
// ---------------------------------------------------------------------------

// One-bit ALU slice. For SUB, the slice inverts b itself, so the caller only
// has to supply carry-in = 1 on the first bit.
module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);
  logic w_b;

  assign w_b  = (op == 2'b11) ? ~b : b;
  assign cout = (a & w_b) | (cin & (a ^ w_b));

  always_comb begin
    s = 1'b0;
    case (op)
      2'b00:   s = ~(a | b);
      2'b01:   s = a ^ b;
      default: s = a ^ w_b ^ cin;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
`ifdef ALU_SERIAL_OVF_EN
  logic             r_ovf;
`endif

  logic             w_slice_s;
  logic             w_slice_cout;

  alu1bit u_slice (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .op   (r_op),
    .s    (w_slice_s),
    .cout (w_slice_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_last = (r_cnt == LAST_BIT);
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand shifters, carry chain flop, result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= 2'b00;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_cnt   <= '0;
      // SUB is a + ~b + 1; the +1 enters as the initial carry
      r_carry <= (op == 2'b11);
      r_cout  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == ST_RUN) begin
      r_res   <= {w_slice_s, r_res[WIDTH-1:1]};
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= r_op[1] & w_slice_cout;
`ifdef ALU_SERIAL_OVF_EN
        // r_carry is the carry into the MSB while the last bit is processed
        r_ovf  <= r_op[1] & (r_carry ^ w_slice_cout);
`endif
      end
    end
  end

  assign s    = r_res;
  assign cout = r_cout;
`ifdef ALU_SERIAL_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed testbench for alu_serial_ctrl (WIDTH=8).
module tb_alu_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
`ifdef ALU_SERIAL_OVF_EN
  logic       ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef ALU_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation. The caller is in IDLE, 1 time unit after an edge.
  // hold    : cycles to keep out_ready low once out_valid is seen
  // pulse   : assert in_valid while busy (must be ignored)
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                       input logic [1:0] top, input logic [7:0] es, input logic ec,
                       input logic eo, input int hold, input logic pulse);
    int cyc;
    a = ta; b = tbv; op = top; in_valid = 1'b1;
    tick();  // accepting edge
    in_valid = pulse;
    // Inputs may change freely after accept
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd8);
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef ALU_SERIAL_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] unexpected X ovf expectation");
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_s"}, 32'(s), 32'(es));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();  // handshake edge
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    $display("[TB] %s a=%h b=%h op=%b -> s=%h cout=%b latency=%0d", tag, ta, tbv, top, es, ec, cyc);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    tick();

    do_op("add_7f_01", 8'h7F, 8'h01, 2'b10, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    do_op("sub_05_07", 8'h05, 8'h07, 2'b11, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub_07_05", 8'h07, 8'h05, 2'b11, 8'h02, 1'b1, 1'b0, 0, 1'b0);
    do_op("nor_f0_0c", 8'hF0, 8'h0C, 2'b00, 8'h03, 1'b0, 1'b0, 0, 1'b0);
    do_op("xor_a5_ff", 8'hA5, 8'hFF, 2'b01, 8'h5A, 1'b0, 1'b0, 0, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 2'b11, 8'h7F, 1'b1, 1'b1, 0, 1'b0);
    // Backpressure with in_valid pulses while busy
    do_op("bp_add_12_34", 8'h12, 8'h34, 2'b10, 8'h46, 1'b0, 1'b0, 5, 1'b1);

    // Reset in the middle of RUN (bit 3 presented to the slice)
    a = 8'hFF; b = 8'h0F; op = 2'b10; in_valid = 1'b1;
    tick();  // accept, bit 0
    in_valid = 1'b0;
    tick(); tick(); tick();  // now at bit 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    $display("[TB] mid-run reset -> idle");
    do_op("add_01_01", 8'h01, 8'h01, 2'b10, 8'h02, 1'b0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
